boid_fb_drawer: RTL

BOID_FB_DRAWER -- requirements
Module: boid_fb_drawer

---
 rtl/boid_pkg.sv | 24 ++
 rtl/fix_to_fb_addr.sv | 33 +++
 rtl/boid_fb_drawer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/boid_pkg.sv
// Shared screen geometry, fixed-point and frame-buffer address types,
// and the drawer FSM state encoding.
// The ERASE state exists only when BOID_FB_ERASE_EN is defined.
package boid_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Signed 16.16 fixed point; the integer pixel is bits [31:16].
  typedef logic signed [31:0] fix16_16;
  typedef logic [18:0]        fb_addr_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CALC  = 3'd2,
`ifdef BOID_FB_ERASE_EN
    ST_ERASE = 3'd3,
`endif
    ST_DRAW  = 3'd4,
    ST_NEXT  = 3'd5
  } draw_state_t;

endpackage

// File: rtl/fix_to_fb_addr.sv
// Converts a 16.16 boid position to a frame-buffer word address.
// Off-screen positions report on_screen=0 and a zero address.
module fix_to_fb_addr
  import boid_pkg::*;
(
  input  fix16_16    x_fix,
  input  fix16_16    y_fix,
  output fb_addr_t   addr,
  output logic       on_screen
);

  localparam logic signed [15:0] W_PIX = 16'(SCREEN_W);
  localparam logic signed [15:0] H_PIX = 16'(SCREEN_H);

  logic signed [15:0] x_pix;
  logic signed [15:0] y_pix;
  logic               unused_frac;

  assign x_pix = x_fix[31:16];
  assign y_pix = y_fix[31:16];

  // Fractional bits never influence which pixel is hit.
  assign unused_frac = ^{x_fix[15:0], y_fix[15:0]};

  assign on_screen = (x_pix >= 16'sd0) && (x_pix < W_PIX) &&
                     (y_pix >= 16'sd0) && (y_pix < H_PIX);

  // Both coordinates are non-negative whenever the address is used.
  assign addr = on_screen
              ? fb_addr_t'(y_pix) * fb_addr_t'(SCREEN_W) + fb_addr_t'(x_pix)
              : '0;

endmodule

// File: rtl/boid_fb_drawer.sv
// Scans every boid slot once per start request and plots each boid into
// the frame buffer, waiting on fb_ready for every write.
// Optional feature macro: BOID_FB_ERASE_EN -- remembers each boid's last
// drawn address and overwrites it with BG_COLOR before drawing again.
module boid_fb_drawer
  import boid_pkg::*;
#(
  parameter int         num_boids  = 2,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(num_boids):0]  which_boid,
  input  logic [31:0]                 x_in_32,
  input  logic [31:0]                 y_in_32,
  output logic [18:0]                 fb_addr,
  output logic [7:0]                  fb_data,
  output logic                        fb_we,
  input  logic                        fb_ready
);

  localparam int WB = $clog2(num_boids) + 1;
  localparam logic [WB-1:0] LAST_BOID = WB'(num_boids - 1);

  draw_state_t state;
  fb_addr_t    pix_addr;
  logic        pix_on;
  logic        write_done;

  fix_to_fb_addr u_fix_to_fb_addr (
    .x_fix     (x_in_32),
    .y_fix     (y_in_32),
    .addr      (pix_addr),
    .on_screen (pix_on)
  );

  // A write state may leave once the pending write is accepted, or at
  // once when there is nothing to write.
  assign write_done = fb_ready || !fb_we;

`ifdef BOID_FB_ERASE_EN
  localparam int SLOT_W = (num_boids > 1) ? $clog2(num_boids) : 1;
  localparam int SLOTS  = 2 ** SLOT_W;

  fb_addr_t           prev_addr [SLOTS];
  logic [SLOTS-1:0]   prev_valid;
  logic [SLOT_W-1:0]  slot;
  fb_addr_t           cur_addr;
  logic               cur_on;

  assign slot = which_boid[SLOT_W-1:0];

  // Remember where each boid was drawn once its DRAW slot completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_valid <= '0;
    end else if (state == ST_DRAW && write_done) begin
      prev_valid[slot] <= cur_on;
      prev_addr[slot]  <= cur_addr;
    end
  end
`else
  localparam logic [7:0] unused_bg_color = BG_COLOR;
`endif

  // Main sequencer: READ -> CALC -> [ERASE] -> DRAW -> NEXT per boid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      which_boid <= '0;
`ifdef BOID_FB_ERASE_EN
      cur_addr   <= '0;
      cur_on     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          which_boid <= '0;
          if (start) begin
            state <= ST_READ;
            busy  <= 1'b1;
          end
        end
        ST_READ: state <= ST_CALC;
        ST_CALC: begin
`ifdef BOID_FB_ERASE_EN
          cur_addr <= pix_addr;
          cur_on   <= pix_on;
          state    <= ST_ERASE;
          fb_we    <= prev_valid[slot];
          fb_addr  <= prev_addr[slot];
          fb_data  <= BG_COLOR;
`else
          state    <= ST_DRAW;
          fb_we    <= pix_on;
          fb_addr  <= pix_addr;
          fb_data  <= BOID_COLOR;
`endif
        end
`ifdef BOID_FB_ERASE_EN
        ST_ERASE: begin
          if (write_done) begin
            state   <= ST_DRAW;
            fb_we   <= cur_on;
            fb_addr <= cur_addr;
            fb_data <= BOID_COLOR;
          end
        end
`endif
        ST_DRAW: begin
          if (write_done) begin
            state <= ST_NEXT;
            fb_we <= 1'b0;
          end
        end
        ST_NEXT: begin
          if (which_boid == LAST_BOID) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b1;
            which_boid <= '0;
          end else begin
            state      <= ST_READ;
            which_boid <= which_boid + WB'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
